// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_in1,
  input  logic [WIDTH-1:0]   req0_in2,
  input  logic [3:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_in1,
  input  logic [WIDTH-1:0]   req1_in2,
  input  logic [3:0]         req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_out,
  output logic               rsp_zero,
  output logic               rsp_error,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [3:0]         alu_op,
  output logic               alu_nvalid_data,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_zero,
  input  logic               alu_error,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  logic [1:0]    state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          g1;
  assign g1 = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = (state == IDLE) && req0_valid && !g1;
  assign req1_ready = (state == IDLE) && g1;
  assign alu_nvalid_data = state == EXEC;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      rsp_out    <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (req0_ready || req1_ready) begin
      alu_in1    <= g1 ? req1_in1 : req0_in1;
      alu_in2    <= g1 ? req1_in2 : req0_in2;
      alu_op     <= g1 ? req1_op : req0_op;
      last_grant <= g1;
      rsp_id     <= g1;
      cnt        <= '0;
      state      <= EXEC;
    end else if (state == EXEC) begin
      cnt <= cnt + CW'(1);
      if (cnt == CW'(ALU_LAT - 1)) begin
        rsp_out   <= alu_out;
        rsp_zero  <= alu_zero;
        rsp_error <= alu_error;
        state     <= RESP;
      end
    end else if (state == RESP && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of alu_arbiter against a behavioural ALU (0 add, 1 sub, 2 mul, 3 div)
module tb_alu_arbiter;
  logic clk = 0, rst = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  logic r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [7:0] r0_in1 = 0, r0_in2 = 0, r1_in1 = 0, r1_in2 = 0;
  logic [3:0] r0_op = 0, r1_op = 0;
  logic rsp_valid, rsp_ready = 1, rsp_zero, rsp_error, rsp_id;
  logic [15:0] rsp_out, alu_out;
  logic [7:0] alu_in1, alu_in2;
  logic [3:0] alu_op;
  logic alu_nv, alu_zero, alu_error, busy;

  logic c_valid = 0, c_ready, c_ready1;
  logic [7:0] c_in1 = 0, c_in2 = 0;
  logic [3:0] c_op = 0;
  logic c_rsp_valid, c_zero, c_error, c_id, c_azero, c_aerror, c_nv, c_busy;
  logic [15:0] c_out, c_aout;
  logic [7:0] c_ain1, c_ain2;
  logic [3:0] c_aop;

  function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] r;
    logic e;
    e = 0;
    case (op)
      4'd0: r = 16'(a) + 16'(b);
      4'd1: r = 16'(a) - 16'(b);
      4'd2: r = 16'(a) * 16'(b);
      4'd3: begin r = (b == 0) ? 16'd0 : 16'(a / b); e = (b == 0); end
      default: begin r = 0; e = 1; end
    endcase
    return {e, r == 0, r};
  endfunction

  assign {alu_error, alu_zero, alu_out} = alu_f(alu_in1, alu_in2, alu_op);
  assign {c_aerror, c_azero, c_aout} = alu_f(c_ain1, c_ain2, c_aop);

  alu_arbiter #(.WIDTH(8), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_in1(r0_in1), .req0_in2(r0_in2), .req0_op(r0_op),
    .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_in1(r1_in1), .req1_in2(r1_in2), .req1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .rsp_error(rsp_error), .rsp_id(rsp_id),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_nvalid_data(alu_nv),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_error(alu_error), .busy(busy));

  alu_arbiter #(.WIDTH(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(c_valid), .req0_ready(c_ready), .req0_in1(c_in1), .req0_in2(c_in2), .req0_op(c_op),
    .req1_valid(1'b0), .req1_ready(c_ready1), .req1_in1(8'd0), .req1_in2(8'd0), .req1_op(4'd0),
    .rsp_valid(c_rsp_valid), .rsp_ready(1'b1), .rsp_out(c_out), .rsp_zero(c_zero),
    .rsp_error(c_error), .rsp_id(c_id),
    .alu_in1(c_ain1), .alu_in2(c_ain2), .alu_op(c_aop), .alu_nvalid_data(c_nv),
    .alu_out(c_aout), .alu_zero(c_azero), .alu_error(c_aerror), .busy(c_busy));

  task automatic do_reset();
    @(negedge clk);
    rst = 1; r0_valid = 0; r1_valid = 0; c_valid = 0; rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  // Waits (bounded) for rsp_valid; n is the number of extra negedges taken.
  task automatic wait_rsp(output int n);
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, output int n);
    int w = 0;
    @(negedge clk);
    if (id) begin r1_valid = 1; r1_in1 = a; r1_in2 = b; r1_op = op; end
    else begin r0_valid = 1; r0_in1 = a; r0_in2 = b; r0_op = op; end
    #1;
    while (!(id ? r1_ready : r0_ready) && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    wait_rsp(n);
    if (w >= 10) n = 99;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({rsp_valid, rsp_out, rsp_zero, rsp_error, rsp_id} !== 20'd0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_out, rsp_zero, rsp_error, rsp_id}); end
    checks++; if ({alu_in1, alu_in2, alu_op, alu_nv, busy, r0_ready, r1_ready} !== 24'd0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_in1, alu_in2, alu_op, alu_nv, busy, r0_ready, r1_ready}); end
    checks++; if ({c_rsp_valid, c_out, c_nv, c_busy, c_ready, c_ready1} !== 21'd0) begin errors++; $display("FAIL reset_dut3 got %h want 0", {c_rsp_valid, c_out, c_nv, c_busy, c_ready, c_ready1}); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    @(negedge clk);
    r0_valid = 1; r0_in1 = 10; r0_in2 = 5; r0_op = 0;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 0;
    #1;
    checks++; if ({alu_nv, busy, rsp_valid, alu_in1, alu_in2} !== {3'b110, 8'd10, 8'd5}) begin errors++; $display("FAIL single_exec got %h want %h", {alu_nv, busy, rsp_valid, alu_in1, alu_in2}, {3'b110, 8'd10, 8'd5}); end
    wait_rsp(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", n); end
    checks++; if ({rsp_out, rsp_zero, rsp_error, rsp_id} !== {16'd15, 3'b000}) begin errors++; $display("FAIL single_rsp got %h want %h", {rsp_out, rsp_zero, rsp_error, rsp_id}, {16'd15, 3'b000}); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, busy, alu_nv, alu_in1} !== {3'b000, 8'd10}) begin errors++; $display("FAIL single_idle got %h want %h", {rsp_valid, busy, alu_nv, alu_in1}, {3'b000, 8'd10}); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      r0_valid = 1; r0_in1 = 10; r0_in2 = 5; r0_op = 2;
      r1_valid = 1; r1_in1 = 10; r1_in2 = 5; r1_op = 1;
      #1;
      checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL sim_grant0 pair %0d got %b want 10", p, {r0_ready, r1_ready}); end
      @(negedge clk);
      r0_valid = 0;
      wait_rsp(n);
      checks++; if ({n[4:0], rsp_out, rsp_id, r1_ready} !== {5'd1, 16'd50, 2'b00}) begin errors++; $display("FAIL sim_rsp0 pair %0d got lat %0d out %0d id %b rdy1 %b want 1 50 0 0", p, n, rsp_out, rsp_id, r1_ready); end
      @(negedge clk);
      #1;
      checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL sim_grant1 pair %0d got %b want 01", p, {r0_ready, r1_ready}); end
      @(negedge clk);
      r1_valid = 0;
      wait_rsp(n);
      checks++; if ({n[4:0], rsp_out, rsp_id} !== {5'd1, 16'd5, 1'b1}) begin errors++; $display("FAIL sim_rsp1 pair %0d got lat %0d out %0d id %b want 1 5 1", p, n, rsp_out, rsp_id); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    rsp_ready = 0;
    run_op(1, 10, 5, 3, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL bp_latency got %0d want 1", n); end
    r0_valid = 1; r0_in1 = 1; r0_in2 = 1; r0_op = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({rsp_valid, rsp_out, rsp_id, r0_ready, r1_ready, busy} !== {1'b1, 16'd2, 4'b1001}) begin errors++; $display("FAIL bp_hold cyc %0d got v%b out %0d id %b rdy %b%b busy %b want v1 2 1 00 1", i, rsp_valid, rsp_out, rsp_id, r0_ready, r1_ready, busy); end
      @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    checks++; if ({rsp_valid, rsp_out} !== {1'b1, 16'd2}) begin errors++; $display("FAIL bp_drain got v%b out %0d want v1 2", rsp_valid, rsp_out); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, busy, r0_ready} !== 3'b001) begin errors++; $display("FAIL bp_after got %b want 001", {rsp_valid, busy, r0_ready}); end
    @(negedge clk);
    r0_valid = 0;
  endtask

  task automatic test_flags();
    int n;
    do_reset();
    run_op(1, 10, 0, 3, n);
    checks++; if ({n[4:0], rsp_error, rsp_id} !== {5'd1, 2'b11}) begin errors++; $display("FAIL div0 got lat %0d err %b id %b want 1 1 1", n, rsp_error, rsp_id); end
    run_op(0, 5, 5, 1, n);
    checks++; if ({n[4:0], rsp_out, rsp_zero, rsp_error, rsp_id} !== {5'd1, 16'd0, 3'b100}) begin errors++; $display("FAIL sub_zero got lat %0d out %0d z%b e%b id %b want 1 0 1 0 0", n, rsp_out, rsp_zero, rsp_error, rsp_id); end
    run_op(0, 3, 4, 4'hf, n);
    checks++; if ({n[4:0], rsp_error, rsp_id, alu_op} !== {5'd1, 2'b10, 4'hf}) begin errors++; $display("FAIL bad_op got lat %0d err %b id %b op %h want 1 1 0 f", n, rsp_error, rsp_id, alu_op); end
  endtask

  task automatic test_lat3();
    int nv = 0, k = -1;
    do_reset();
    @(negedge clk);
    c_valid = 1; c_in1 = 0; c_in2 = 5; c_op = 0;
    #1;
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL lat3_ready got %b want 1", c_ready); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      c_valid = 0;
      #1;
      nv += int'(c_nv);
      if (c_rsp_valid && k < 0) k = i;
    end
    checks++; if (nv !== 3) begin errors++; $display("FAIL lat3_nvalid got %0d cycles want 3", nv); end
    checks++; if (k !== 4) begin errors++; $display("FAIL lat3_latency got %0d want 4", k); end
    checks++; if ({c_out, c_id} !== {16'd5, 1'b0}) begin errors++; $display("FAIL lat3_out got %0d id %b want 5 0", c_out, c_id); end
  endtask

  task automatic test_reset_exec();
    int n;
    do_reset();
    run_op(0, 1, 1, 0, n);
    @(negedge clk);
    r0_valid = 1; r0_in1 = 7; r0_in2 = 7; r0_op = 0;
    #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL rx_accept got %b want 1", r0_ready); end
    @(negedge clk);
    r0_valid = 0;
    rst = 1;
    #1;
    checks++; if (alu_nv !== 1'b1) begin errors++; $display("FAIL rx_exec got %b want 1", alu_nv); end
    @(negedge clk);
    rst = 0;
    r0_valid = 1; r1_valid = 1; r0_op = 2; r1_op = 1;
    #1;
    checks++; if ({rsp_valid, busy, r0_ready, r1_ready} !== 4'b0010) begin errors++; $display("FAIL rx_after got %b want 0010", {rsp_valid, busy, r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 0; r1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_flags();
    test_lat3();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
